// File: rtl/trap_sequencer_if.sv
// Shared CSR types plus the commit-stage -> trap_sequencer request interface.
// The package sits here so the interface and the sequencer share one definition.
package trap_sequencer_pkg;
  localparam int CSR_XLEN = 64;

  typedef logic [CSR_XLEN-1:0] csr_t;
  typedef logic [11:0]         csr_addr;

  // Only the CSRs the sequencer reads; the CSR file drives these combinationally.
  typedef struct packed {
    csr_t mstatus;
    csr_t mtvec;
    csr_t mepc;
  } csr_pack;

  localparam csr_addr CSR_MSTATUS = 12'h300;
  localparam csr_addr CSR_MTVEC   = 12'h305;
  localparam csr_addr CSR_MEPC    = 12'h341;
  localparam csr_addr CSR_MCAUSE  = 12'h342;
  localparam csr_addr CSR_MTVAL   = 12'h343;
endpackage

// Handshake: a request transfers on a rising clk edge where trap_valid && trap_ready;
// the payload must be stable while trap_valid is high, trap_ready never depends on trap_valid.
interface trap_sequencer_if #(parameter int XLEN = 64);
  logic            trap_valid;
  logic            trap_ready;
  logic            trap_is_mret;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_tval;

  modport master (
    output trap_valid, trap_is_mret, trap_cause, trap_pc, trap_tval,
    input  trap_ready
  );

  modport slave (
    input  trap_valid, trap_is_mret, trap_cause, trap_pc, trap_tval,
    output trap_ready
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap-entry / MRET sequencer: writes mepc, mcause, mtval, mstatus one per cycle
// through the CSR write port, then pulses a fetch redirect and tracks privilege.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  trap_sequencer_if.slave       trap,
  input  csr_pack               csrs,
  output logic                  csr_write_enable,
  output csr_addr               csr_dest_addr,
  output csr_t                  csr_write_data,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [1:0]            priv_mode,
  output logic                  busy,
  output logic [2:0]            o_dbg_state
);

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STATUS,
    S_M_STATUS,
    S_REDIRECT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_priv;
  logic [1:0]      w_priv_next;
  logic            r_is_mret;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic            w_accept;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_status;

  assign w_accept        = trap.trap_valid && (r_state == S_IDLE);
  assign trap.trap_ready = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign priv_mode       = r_priv;
  assign o_dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_priv  <= 2'b11;
    end else begin
      r_state <= w_next;
      r_priv  <= w_priv_next;
    end
  end

  // Request payload is only captured on acceptance, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_mret <= trap.trap_is_mret;
      r_cause   <= trap.trap_cause;
      r_pc      <= trap.trap_pc;
      r_tval    <= trap.trap_tval;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_priv_next      = r_priv;
    csr_write_enable = 1'b0;
    csr_dest_addr    = '0;
    csr_write_data   = '0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    w_base           = {csrs.mtvec[XLEN-1:2], 2'b00};
    w_status         = csrs.mstatus;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = trap.trap_is_mret ? S_M_STATUS : S_W_EPC;
      end
      S_W_EPC: begin
        csr_write_enable = 1'b1;
        csr_dest_addr    = CSR_MEPC;
        csr_write_data   = {r_pc[XLEN-1:2], 2'b00};
        w_next           = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_write_enable = 1'b1;
        csr_dest_addr    = CSR_MCAUSE;
        csr_write_data   = r_cause;
        w_next           = S_W_TVAL;
      end
      S_W_TVAL: begin
        csr_write_enable = 1'b1;
        csr_dest_addr    = CSR_MTVAL;
        csr_write_data   = r_tval;
        w_next           = S_W_STATUS;
      end
      S_W_STATUS: begin
        w_status[MPIE_BIT]      = csrs.mstatus[MIE_BIT];
        w_status[MIE_BIT]       = 1'b0;
        w_status[MPP_HI:MPP_LO] = r_priv;
        csr_write_enable        = 1'b1;
        csr_dest_addr           = CSR_MSTATUS;
        csr_write_data          = w_status;
        w_priv_next             = 2'b11;
        w_next                  = S_REDIRECT;
      end
      S_M_STATUS: begin
        w_status[MIE_BIT]       = csrs.mstatus[MPIE_BIT];
        w_status[MPIE_BIT]      = 1'b1;
        w_status[MPP_HI:MPP_LO] = 2'b00;
        csr_write_enable        = 1'b1;
        csr_dest_addr           = CSR_MSTATUS;
        csr_write_data          = w_status;
        // Only M and U exist: any MPP other than M returns to U.
        w_priv_next = (csrs.mstatus[MPP_HI:MPP_LO] == 2'b11) ? 2'b11 : 2'b00;
        w_next      = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (r_is_mret) begin
          redirect_pc = csrs.mepc;
        end else if (csrs.mtvec[1:0] == 2'b01 && r_cause[XLEN-1]) begin
          redirect_pc = w_base + {r_cause[XLEN-3:0], 2'b00};
        end else begin
          redirect_pc = w_base;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap-entry / MRET sequencer sitting directly upstream of the machine-mode CSR file. It accepts one trap or MRET request from the commit stage and writes mepc, mcause, mtval and mstatus through the CSR file's single write port, one CSR per cycle. It then issues a one-cycle PC redirect to the fetch stage and tracks the current privilege mode.

## Interface
Parameters:
- XLEN, 64, CSR and PC data width; equals the width of csr_t.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- trap_valid  in  1  request present.
- trap_ready  out  1  sequencer idle; the request is accepted when trap_valid && trap_ready.
- trap_is_mret  in  1  1 = MRET request, 0 = exception or interrupt entry.
- trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt.
- trap_pc  in  XLEN  PC of the faulting/interrupted instruction.
- trap_tval  in  XLEN  mtval value.
- csrs  in  csr_pack  current CSR contents from the CSR file (combinational; a write is visible the cycle after it is issued).
- csr_write_enable  out  1  write strobe to the CSR file.
- csr_dest_addr  out  csr_addr  target CSR.
- csr_write_data  out  csr_t  data to write; the CSR file applies its own masks.
- redirect_valid  out  1  one-cycle pulse: fetch must jump to redirect_pc.
- redirect_pc  out  XLEN  redirect target.
- priv_mode  out  2  current privilege: 2'b11 = M, 2'b00 = U.
- busy  out  1  equals !trap_ready.

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT.
- IDLE: trap_ready = 1. On acceptance, latch cause, pc, tval and is_mret.
  - Next state is M_STATUS if is_mret, else W_EPC.
  - Inputs are ignored while not IDLE.
- W_EPC: write CSR_MEPC = latched pc with bits [1:0] cleared. Next state W_CAUSE.
- W_CAUSE: write CSR_MCAUSE = latched cause. Next state W_TVAL.
- W_TVAL: write CSR_MTVAL = latched tval. Next state W_STATUS.
- W_STATUS: write CSR_MSTATUS = csrs.mstatus with three fields changed:
  - MPIE (bit 7) = old MIE (bit 3);
  - MIE = 0;
  - MPP (bits 12:11) = priv_mode.
  - priv_mode <= 2'b11. Next state REDIRECT.
- M_STATUS: write CSR_MSTATUS = csrs.mstatus with three fields changed:
  - MIE = old MPIE;
  - MPIE = 1;
  - MPP = 2'b00.
  - priv_mode <= old MPP, where MPP value 2'b11 gives M and any other value gives U. Next state REDIRECT.
- REDIRECT: redirect_valid = 1 for this cycle only. Next state IDLE.
  - MRET: redirect_pc = csrs.mepc.
  - Trap, base = csrs.mtvec with bits [1:0] cleared:
    - if mtvec[1:0] == 2'b01 and cause[XLEN-1] == 1, redirect_pc = base + 4 × cause[XLEN-2:0], truncated to XLEN (wraps modulo 2^XLEN);
    - otherwise redirect_pc = base.
- csr_write_enable = 1 only in W_EPC, W_CAUSE, W_TVAL, W_STATUS and M_STATUS.
  - Outside those states, csr_dest_addr and csr_write_data are driven to 0.
- No other CSR is ever written. The sequencer never writes mcycle, so it has no write-port conflict with a cycle counter.

## Timing
- Reset (rst == 0 at a clk edge): state = IDLE, priv_mode = 2'b11, trap_ready = 1, busy = 0.
  - csr_write_enable, redirect_valid, redirect_pc, csr_dest_addr and csr_write_data are all 0.
  - Reset mid-sequence aborts it immediately. CSR writes already issued are not undone, and no redirect is issued.
- Trap latency, request accepted at edge N:
  - writes at cycles N+1 (mepc), N+2 (mcause), N+3 (mtval), N+4 (mstatus);
  - redirect_valid high in cycle N+5;
  - trap_ready high again in cycle N+6.
- MRET latency: mstatus write in cycle N+1, redirect in N+2, ready in N+3.
- No back-to-back acceptance. trap_ready is low from the cycle after acceptance through the REDIRECT cycle.
- A request held valid during busy is accepted on the first IDLE cycle.
- W_STATUS and M_STATUS read csrs.mstatus combinationally. The REDIRECT cycle reads csrs.mtvec and csrs.mepc combinationally, so an MRET sees the mepc value current at the time of the redirect.
- trap_valid deasserted in IDLE: no state change, all outputs idle.

## Test plan
- Reset: hold rst = 0 for 2 cycles with trap_valid = 1 -> no acceptance, priv_mode = 2'b11, redirect_valid = 0, csr_write_enable = 0.
- Exception, direct mode. Setup: mtvec = 0x8000_0100, mstatus.MIE = 1, priv = M. Request: cause = 2, pc = 0x8000_0042, tval = 0xDEAD.
  - Writes in order: mepc = 0x8000_0040, mcause = 2, mtval = 0xDEAD.
  - mstatus write has MIE = 0, MPIE = 1, MPP = 3.
  - Redirect to 0x8000_0100 in cycle N+5.
- Vectored interrupt: mtvec = 0x8000_0001, cause = 0x8000_0000_0000_0007 -> redirect_pc = 0x8000_001C.
- MRET: mstatus.MPIE = 1, MPP = 0, mepc = 0x8000_0200 -> mstatus write has MIE = 1, MPIE = 1, MPP = 0; priv_mode = 0; redirect 0x8000_0200 in cycle N+2.
- Held request: assert a second trap_valid during W_CAUSE -> not accepted until the cycle after REDIRECT; exactly 4 writes per trap, with no overlap between traps.
- Reset asserted in W_TVAL -> no W_STATUS write, no redirect; after reset release, trap_ready = 1 and priv_mode = 3.
